// File: rtl/ysyx_22041412_div_ctrl.sv
// ---------------------------------------------------------------------------
// ysyx_22041412_div_ctrl
//
// Issue/retire controller sitting between the EXU and the iterative divider.
// Takes one RV64M DIV/DIVU/REM/REMU (and *W) op at a time. Divide-by-zero and
// signed overflow are answered locally without starting the divider. All other
// ops launch the divider once. The controller then waits for the divider's
// result, sign-extends *W results, and returns the result plus the rd tag over
// a valid/ready port.
//
// Handshake semantics (both ports): a transfer happens on a rising clk edge
// where valid and ready are both high. Once valid is raised, the payload stays
// stable until that edge. Only a flush or rst withdraws valid.
//
// Optional feature: define YSYX_22041412_DIV_CACHE_EN to add a one-entry
// result cache. A request that matches the last completed divider op
// (op, word, src1, src2) is answered from the cache without a divider launch.
//
// Ports
//   clk, rst           clock, synchronous active-high reset
//   i_req_*/o_req_ready request port from the EXU (o_req_ready high only in IDLE)
//   i_flush            pipeline kill; drops the op in flight
//   o_div_*            launch pulse and latched operands to the divider
//   i_div_out_valid,
//   i_div_result       one-cycle result pulse from the divider
//   o_resp_*/i_resp_ready result port to the consumer
//   o_busy             high whenever the controller is not IDLE
//   o_dbg_state        current FSM state (encoding of state_t)
// ---------------------------------------------------------------------------
module ysyx_22041412_div_ctrl #(
    parameter int XLEN  = 64,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    // request from EXU
    input  logic             i_req_valid,
    output logic             o_req_ready,
    input  logic [1:0]       i_req_op,
    input  logic             i_req_word,
    input  logic [XLEN-1:0]  i_req_src1,
    input  logic [XLEN-1:0]  i_req_src2,
    input  logic [TAG_W-1:0] i_req_tag,
    input  logic             i_flush,
    // divider launch
    output logic             o_div_valid,
    output logic [XLEN-1:0]  o_div_dividend,
    output logic [XLEN-1:0]  o_div_divisor,
    output logic             o_div_divw,
    output logic             o_div_signed,
    output logic             o_div_mode,
    // divider result
    input  logic             i_div_out_valid,
    input  logic [XLEN-1:0]  i_div_result,
    // response to consumer
    output logic             o_resp_valid,
    input  logic             i_resp_ready,
    output logic [XLEN-1:0]  o_resp_data,
    output logic [TAG_W-1:0] o_resp_tag,
    output logic             o_busy,
    output logic [2:0]       o_dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t            r_state;
    logic [1:0]        r_op;
    logic              r_word;
    logic [XLEN-1:0]   r_src1;
    logic [XLEN-1:0]   r_src2;
    logic [TAG_W-1:0]  r_tag;
    logic              r_div_valid;
    logic              r_resp_valid;
    logic [XLEN-1:0]   r_resp_data;

    // ---------------------------------------------------------------------
    // Special-case detection on the incoming request. *W ops only look at
    // the low 32 bits of each operand.
    // ---------------------------------------------------------------------
    logic              w_is_rem;
    logic              w_is_uns;
    logic [XLEN-1:0]   w_src1_eff;
    logic              w_div0;
    logic              w_ovf;
    logic              w_special;
    logic [XLEN-1:0]   w_special_result;
    logic [XLEN-1:0]   w_div_result_ext;
    logic              w_accept;

    assign w_is_rem   = i_req_op[1];
    assign w_is_uns   = i_req_op[0];
    // The dividend as the final rd value would show it: a *W op returns the
    // low word sign-extended, even for the unsigned variants.
    assign w_src1_eff = i_req_word ? {{(XLEN-32){i_req_src1[31]}}, i_req_src1[31:0]}
                                   : i_req_src1;
    assign w_div0     = i_req_word ? (i_req_src2[31:0] == 32'd0)
                                   : (i_req_src2 == '0);
    assign w_ovf      = !w_is_uns &&
                        (i_req_word ? ((i_req_src1[31:0] == 32'h8000_0000) &&
                                       (i_req_src2[31:0] == 32'hFFFF_FFFF))
                                    : ((i_req_src1 == MIN_NEG) && (i_req_src2 == '1)));
    assign w_special  = w_div0 || w_ovf;

    // x/0: quotient all ones, remainder x. MIN/-1: quotient MIN, remainder 0.
    // An all-ones quotient is already its own sign extension.
    always_comb begin
        w_special_result = '0;
        if (w_div0)
            w_special_result = w_is_rem ? w_src1_eff : '1;
        else
            w_special_result = w_is_rem ? '0 : w_src1_eff;
    end

    // The divider leaves the upper word of a *W result undefined.
    assign w_div_result_ext = r_word ? {{(XLEN-32){i_div_result[31]}}, i_div_result[31:0]}
                                     : i_div_result;

    assign w_accept = i_req_valid && !i_flush;

`ifdef YSYX_22041412_DIV_CACHE_EN
    logic              r_c_valid;
    logic [1:0]        r_c_op;
    logic              r_c_word;
    logic [XLEN-1:0]   r_c_src1;
    logic [XLEN-1:0]   r_c_src2;
    logic [XLEN-1:0]   r_c_result;
    logic              w_c_hit;

    assign w_c_hit = r_c_valid && (r_c_op == i_req_op) && (r_c_word == i_req_word) &&
                     (r_c_src1 == i_req_src1) && (r_c_src2 == i_req_src2);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_c_valid  <= 1'b0;
            r_c_op     <= '0;
            r_c_word   <= 1'b0;
            r_c_src1   <= '0;
            r_c_src2   <= '0;
            r_c_result <= '0;
        end else if (r_state == S_WAIT && i_div_out_valid && !i_flush) begin
            r_c_valid  <= 1'b1;
            r_c_op     <= r_op;
            r_c_word   <= r_word;
            r_c_src1   <= r_src1;
            r_c_src2   <= r_src2;
            r_c_result <= w_div_result_ext;
        end
    end
`else
    logic              w_c_hit;
    logic [XLEN-1:0]   r_c_result;

    assign w_c_hit    = 1'b0;
    assign r_c_result = '0;
`endif

    // ---------------------------------------------------------------------
    // Control FSM. The launch pulse and the response are registered. The
    // state they come from is entered on the same edge.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_op         <= '0;
            r_word       <= 1'b0;
            r_src1       <= '0;
            r_src2       <= '0;
            r_tag        <= '0;
            r_div_valid  <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_data  <= '0;
        end else begin
            r_div_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op   <= i_req_op;
                        r_word <= i_req_word;
                        r_src1 <= i_req_src1;
                        r_src2 <= i_req_src2;
                        r_tag  <= i_req_tag;
                        if (w_special) begin
                            r_resp_data  <= w_special_result;
                            r_resp_valid <= 1'b1;
                            r_state      <= S_DONE;
                        end else if (w_c_hit) begin
                            r_resp_data  <= r_c_result;
                            r_resp_valid <= 1'b1;
                            r_state      <= S_DONE;
                        end else begin
                            r_div_valid <= 1'b1;
                            r_state     <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    r_state <= i_flush ? S_IDLE : S_WAIT;
                end
                S_WAIT: begin
                    if (i_div_out_valid) begin
                        // A flush in the same cycle as the result discards it.
                        // The divider is already free, so there is nothing to drain.
                        if (i_flush) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_resp_data  <= w_div_result_ext;
                            r_resp_valid <= 1'b1;
                            r_state      <= S_DONE;
                        end
                    end else if (i_flush) begin
                        // The divider cannot be aborted, so its result is absorbed in DRAIN.
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (i_div_out_valid)
                        r_state <= S_IDLE;
                end
                S_DONE: begin
                    if (i_flush || i_resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_state      <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // A flush arriving while ISSUE is being presented blocks the launch.
    // Otherwise the divider would start an op whose result nobody drains.
    assign o_div_valid    = r_div_valid && !i_flush;
    assign o_div_dividend = r_src1;
    assign o_div_divisor  = r_src2;
    assign o_div_divw     = r_word;
    assign o_div_signed   = ~r_op[0];
    assign o_div_mode     = r_op[1];

    assign o_req_ready    = (r_state == S_IDLE);
    assign o_busy         = (r_state != S_IDLE);
    assign o_resp_valid   = r_resp_valid;
    assign o_resp_data    = r_resp_data;
    assign o_resp_tag     = r_tag;
    assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_ysyx_22041412_div_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ysyx_22041412_div_ctrl
//
// Bench for the divider issue/retire controller. It contains a behavioural
// divider with a programmable latency and a reference model of RV64M
// division. Each accepted request that must produce a response pushes
// {tag, data} onto exp_q. The response monitor pops exp_q on every response
// handshake.
// ---------------------------------------------------------------------------
module tb_ysyx_22041412_div_ctrl;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ISSUE = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_DRAIN = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;
    localparam logic [63:0] MIN64   = 64'h8000_0000_0000_0000;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = '0;
    logic        req_word = 1'b0;
    logic [63:0] req_src1 = '0;
    logic [63:0] req_src2 = '0;
    logic [4:0]  req_tag = '0;
    logic        flush = 1'b0;
    logic        div_valid;
    logic [63:0] div_dividend;
    logic [63:0] div_divisor;
    logic        div_divw;
    logic        div_signed;
    logic        div_mode;
    logic        div_out_valid = 1'b0;
    logic [63:0] div_result = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [63:0] resp_data;
    logic [4:0]  resp_tag;
    logic        busy;
    logic [2:0]  dbg_state;

    ysyx_22041412_div_ctrl #(.XLEN(64), .TAG_W(5)) dut (
        .clk             (clk),
        .rst             (rst),
        .i_req_valid     (req_valid),
        .o_req_ready     (req_ready),
        .i_req_op        (req_op),
        .i_req_word      (req_word),
        .i_req_src1      (req_src1),
        .i_req_src2      (req_src2),
        .i_req_tag       (req_tag),
        .i_flush         (flush),
        .o_div_valid     (div_valid),
        .o_div_dividend  (div_dividend),
        .o_div_divisor   (div_divisor),
        .o_div_divw      (div_divw),
        .o_div_signed    (div_signed),
        .o_div_mode      (div_mode),
        .i_div_out_valid (div_out_valid),
        .i_div_result    (div_result),
        .o_resp_valid    (resp_valid),
        .i_resp_ready    (resp_ready),
        .o_resp_data     (resp_data),
        .o_resp_tag      (resp_tag),
        .o_busy          (busy),
        .o_dbg_state     (dbg_state)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [63:0] ref_div(input logic [1:0] op, input logic word,
                                            input logic [63:0] a, input logic [63:0] b);
        logic [31:0] a32, b32, r32;
        logic [63:0] r;
        a32 = a[31:0];
        b32 = b[31:0];
        if (word) begin
            if (b32 == 32'd0)
                r32 = op[1] ? a32 : 32'hFFFF_FFFF;
            else if (!op[0] && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF)
                r32 = op[1] ? 32'd0 : a32;
            else if (op[0])
                r32 = op[1] ? (a32 % b32) : (a32 / b32);
            else
                r32 = op[1] ? 32'($signed(a32) % $signed(b32)) : 32'($signed(a32) / $signed(b32));
            r = {{32{r32[31]}}, r32};
        end else begin
            if (b == 64'd0)
                r = op[1] ? a : 64'hFFFF_FFFF_FFFF_FFFF;
            else if (!op[0] && a == MIN64 && b == 64'hFFFF_FFFF_FFFF_FFFF)
                r = op[1] ? 64'd0 : a;
            else if (op[0])
                r = op[1] ? (a % b) : (a / b);
            else
                r = op[1] ? 64'($signed(a) % $signed(b)) : 64'($signed(a) / $signed(b));
        end
        return r;
    endfunction

    function automatic bit is_special(input logic [1:0] op, input logic word,
                                      input logic [63:0] a, input logic [63:0] b);
        if (word)
            return (b[31:0] == 32'd0) ||
                   (!op[0] && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF);
        return (b == 64'd0) || (!op[0] && a == MIN64 && b == 64'hFFFF_FFFF_FFFF_FFFF);
    endfunction

    // ---------------- behavioural divider ----------------
    // It samples the launch at the negedge and raises out_valid next_lat
    // negedges later for one cycle. A *W result carries junk in its upper word.
    int          next_lat = 3;
    int          div_cnt = 0;
    int          launches = 0;
    int          completions = 0;
    logic [63:0] d_res;

    initial begin
        forever begin
            @(negedge clk);
            div_out_valid = 1'b0;
            if (rst) begin
                div_cnt = 0;
            end else begin
                if (div_cnt > 0) begin
                    div_cnt--;
                    if (div_cnt == 0) begin
                        div_out_valid = 1'b1;
                        div_result    = d_res;
                        completions++;
                    end
                end
                if (div_valid) begin
                    launches++;
                    div_cnt = next_lat;
                    d_res = ref_div({div_mode, ~div_signed}, div_divw, div_dividend, div_divisor);
                    if (div_divw)
                        d_res[63:32] = 32'hDEAD_BEEF;
                end
            end
        end
    end

    // ---------------- scoreboard / response monitor ----------------
    logic [68:0] exp_q[$];

    initial begin
        logic [68:0] e;
        forever begin
            @(negedge clk);
            if (!rst && resp_valid && resp_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_resp", 64'(resp_valid), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("resp_data", resp_data, e[63:0]);
                    check("resp_tag", 64'(resp_tag), 64'(e[68:64]));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_idle();
        int c = 0;
        while (!req_ready && c < 200) begin
            @(posedge clk); #1;
            c++;
        end
        if (!req_ready) check("wait_idle_timeout", 64'(req_ready), 64'd1);
    endtask

    task automatic present(input logic [1:0] op, input logic word, input logic [63:0] a,
                           input logic [63:0] b, input logic [4:0] tag);
        req_valid = 1'b1;
        req_op    = op;
        req_word  = word;
        req_src1  = a;
        req_src2  = b;
        req_tag   = tag;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_src1  = {$urandom, $urandom};
        req_src2  = {$urandom, $urandom};
        req_tag   = 5'($urandom);
    endtask

    // Full transaction: request, wait for response, hold resp_ready low for
    // 'hold' cycles, then take it. 'no_launch' marks ops answered without the divider.
    task automatic do_op(input string name, input logic [1:0] op, input logic word,
                         input logic [63:0] a, input logic [63:0] b, input logic [4:0] tag,
                         input logic [63:0] exp, input int hold, input bit no_launch);
        int          l0;
        int          c;
        logic [63:0] d0;
        logic [4:0]  t0;
        wait_idle();
        l0 = launches;
        exp_q.push_back({tag, exp});
        present(op, word, a, b, tag);
        if (no_launch)
            check({name, "_lat1_valid"}, 64'(resp_valid), 64'd1);
        else
            check({name, "_req_ready_low"}, 64'(req_ready), 64'd0);
        c = 0;
        while (!resp_valid && c < 200) begin
            @(posedge clk); #1;
            c++;
        end
        check({name, "_resp_valid"}, 64'(resp_valid), 64'd1);
        d0 = resp_data;
        t0 = resp_tag;
        repeat (hold) begin
            @(posedge clk); #1;
        end
        if (hold > 0) begin
            check({name, "_hold_valid"}, 64'(resp_valid), 64'd1);
            check({name, "_hold_data"}, resp_data, d0);
            check({name, "_hold_tag"}, 64'(resp_tag), 64'(t0));
        end
        check({name, "_done_ready_low"}, 64'(req_ready), 64'd0);
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        check({name, "_launches"}, 64'(launches - l0), no_launch ? 64'd0 : 64'd1);
        check({name, "_back_idle"}, 64'(dbg_state), 64'(ST_IDLE));
    endtask

    function automatic logic [63:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 64'd0;
            1:       return 64'hFFFF_FFFF_FFFF_FFFF;
            2:       return MIN64;
            3:       return {$urandom, $urandom};
            4:       return 64'($urandom_range(0, 100));
            default: return {$urandom, 32'h8000_0000};
        endcase
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        int          l0;
        int          c0;
        int          c;
        bit          saw_resp;
        bit          cache_on;
        logic [1:0]  r_op;
        logic        r_w;
        logic [63:0] r_a, r_b;
`ifdef YSYX_22041412_DIV_CACHE_EN
        cache_on = 1'b1;
`else
        cache_on = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // reset state
        check("rst_state", 64'(dbg_state), 64'(ST_IDLE));
        check("rst_req_ready", 64'(req_ready), 64'd1);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_div_valid", 64'(div_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_resp_data", resp_data, 64'd0);
        check("rst_resp_tag", 64'(resp_tag), 64'd0);

        // directed vectors, expected values written out by hand
        next_lat = 4;
        do_op("div_100_7", 2'b00, 1'b0, 64'd100, 64'd7, 5'd11, 64'd14, 0, 1'b0);
        do_op("rem_m7_2", 2'b10, 1'b0, -64'sd7, 64'd2, 5'd12, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1'b0);
        do_op("remu_7_0", 2'b11, 1'b0, 64'd7, 64'd0, 5'd13, 64'd7, 0, 1'b1);
        do_op("div_min_m1", 2'b00, 1'b0, MIN64, 64'hFFFF_FFFF_FFFF_FFFF, 5'd14, MIN64, 0, 1'b1);
        do_op("rem_min_m1", 2'b10, 1'b0, MIN64, 64'hFFFF_FFFF_FFFF_FFFF, 5'd15, 64'd0, 0, 1'b1);
        do_op("divw_min_1", 2'b00, 1'b1, 64'h1234_5678_8000_0000, 64'hABCD_0000_0000_0001,
              5'd16, 64'hFFFF_FFFF_8000_0000, 0, 1'b0);
        do_op("divuw_fffe_2", 2'b01, 1'b1, 64'h0000_0001_FFFF_FFFE, 64'h5555_0000_0000_0002,
              5'd17, 64'h0000_0000_7FFF_FFFF, 0, 1'b0);
        do_op("divuw_x_0", 2'b01, 1'b1, 64'h0000_0000_0000_0005, 64'hFFFF_FFFF_0000_0000,
              5'd18, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1'b1);
        do_op("remw_div0", 2'b10, 1'b1, 64'h0000_0000_8000_0003, 64'h1_0000_0000,
              5'd19, 64'hFFFF_FFFF_8000_0003, 0, 1'b1);
        do_op("divw_ovf", 2'b00, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF,
              5'd20, 64'hFFFF_FFFF_8000_0000, 0, 1'b1);

        // response held off for 5 cycles: data and tag must not move
        do_op("hold5", 2'b01, 1'b0, 64'd1000, 64'd9, 5'd21, 64'd111, 5, 1'b0);

        // flush in WAIT: drain the divider, no response, then a clean op
        next_lat = 6;
        wait_idle();
        l0 = launches;
        c0 = completions;
        present(2'b01, 1'b0, 64'd50, 64'd5, 5'd3);
        @(posedge clk); #1;
        check("fw_in_wait", 64'(dbg_state), 64'(ST_WAIT));
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("fw_drain", 64'(dbg_state), 64'(ST_DRAIN));
        saw_resp = 1'b0;
        c = 0;
        while (busy && c < 50) begin
            if (resp_valid) saw_resp = 1'b1;
            @(posedge clk); #1;
            c++;
        end
        check("fw_busy_end", 64'(busy), 64'd0);
        check("fw_no_resp", 64'(saw_resp), 64'd0);
        check("fw_div_done", 64'(completions - c0), 64'd1);
        check("fw_one_launch", 64'(launches - l0), 64'd1);
        next_lat = 2;
        do_op("divu_9_3", 2'b01, 1'b0, 64'd9, 64'd3, 5'd4, 64'd3, 0, 1'b0);

        // flush during ISSUE: the launch must be suppressed
        wait_idle();
        l0 = launches;
        present(2'b00, 1'b0, 64'd77, 64'd5, 5'd5);
        check("fi_in_issue", 64'(dbg_state), 64'(ST_ISSUE));
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("fi_idle", 64'(dbg_state), 64'(ST_IDLE));
        repeat (4) @(posedge clk);
        #1 check("fi_no_launch", 64'(launches - l0), 64'd0);

        // flush while a request is offered in IDLE: not accepted
        req_valid = 1'b1;
        req_op = 2'b00; req_word = 1'b0; req_src1 = 64'd8; req_src2 = 64'd2;
        flush = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        flush = 1'b0;
        check("fidle_not_taken", 64'(dbg_state), 64'(ST_IDLE));

        // flush in DONE: response withdrawn
        present(2'b11, 1'b0, 64'd7, 64'd0, 5'd6);
        check("fd_done", 64'(resp_valid), 64'd1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("fd_resp_drop", 64'(resp_valid), 64'd0);
        check("fd_idle", 64'(dbg_state), 64'(ST_IDLE));

        // flush coinciding with the divider result: straight back to IDLE
        next_lat = 3;
        c0 = completions;
        present(2'b00, 1'b0, 64'd20, 64'd4, 5'd7);
        c = 0;
        do begin
            @(negedge clk); #1;
            c++;
        end while (!div_out_valid && c < 20);
        check("fs_out_valid", 64'(div_out_valid), 64'd1);
        check("fs_in_wait", 64'(dbg_state), 64'(ST_WAIT));
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("fs_idle", 64'(dbg_state), 64'(ST_IDLE));
        check("fs_resp", 64'(resp_valid), 64'd0);

        // reset in the middle of an op
        next_lat = 5;
        present(2'b00, 1'b0, 64'd90, 64'd9, 5'd8);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_mid_idle", 64'(dbg_state), 64'(ST_IDLE));
        check("rst_mid_resp", 64'(resp_valid), 64'd0);
        repeat (8) @(posedge clk);
        #1;

        // DIV 100/7 again: served from the cache when it is built in
        next_lat = 2;
        do_op("div_100_7_a", 2'b00, 1'b0, 64'd100, 64'd7, 5'd9, 64'd14, 0, 1'b0);
        do_op("div_100_7_b", 2'b00, 1'b0, 64'd100, 64'd7, 5'd10, 64'd14, 2, cache_on);

        // randomized ops against the reference model
        for (int i = 0; i < 24; i++) begin
            r_op = 2'($urandom_range(0, 3));
            r_w  = 1'($urandom_range(0, 1));
            r_a  = pick_operand();
            r_b  = pick_operand();
            if (r_b == 64'd0 && $urandom_range(0, 1) == 1) r_b = 64'($urandom_range(1, 9));
            next_lat = $urandom_range(1, 6);
            // distinct random operands rarely repeat, so the cache only
            // matters when the same op is drawn twice in a row
            do_op("rand", r_op, r_w, r_a, r_b, 5'(i), ref_div(r_op, r_w, r_a, r_b),
                  $urandom_range(0, 3), is_special(r_op, r_w, r_a, r_b));
        end

        repeat (3) @(posedge clk);
        #1 check("final_q_empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
